axis_uart_rx: RTL and testbench

UART receiver that turns the serial line back into an AXI-Stream byte stream, reconstructing packet boundaries from line idle time. It is the receive-side counterpart of the FIFO-fed UART transmitter: its `uart_rx` input connects to that block's `uart_tx` output (loopback or link partner), and its `m_axis_*` master feeds downstream logic. An idle gap of `IDLE_BITS` bit-times after a byte marks that byte with `m_axis_last`.

---
 rtl/axis_uart_rx.sv | 234 +++++++++++++++++++++++
 tb/tb_axis_uart_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_rx.sv
// axis_uart_rx -- UART receiver producing an AXI-Stream byte stream.
//
// Serial characters on uart_rx are deserialised and emitted on the m_axis
// master. Packet boundaries come from line idle time: a received byte is
// held in a pending register until either another byte arrives (the held
// byte goes out with last=0) or the line stays idle for IDLE_BITS bit-times
// (the held byte goes out with last=1).
//
// Optional feature: define AXIS_UART_RX_PARITY_EN to expect one even-parity
// bit after the data bits; a parity mismatch is reported like a bad stop bit.
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   uart_rx       serial line, idle high, asynchronous to clk
//   m_axis_data   received byte
//   m_axis_valid  beat valid, held until accepted
//   m_axis_last   final byte of a packet
//   m_axis_ready  downstream accept
//   frame_err     one-cycle pulse: character rejected (bad stop/parity)
//   overrun       one-cycle pulse: byte dropped, output slot was busy
module axis_uart_rx #(
  parameter int WIDTH     = 8,
  parameter int CLK_RATE  = 50000000,
  parameter int BAUD      = 115200,
  parameter int IDLE_BITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  output logic [WIDTH-1:0] m_axis_data,
  output logic             m_axis_valid,
  output logic             m_axis_last,
  input  logic             m_axis_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CPB    = CLK_RATE / BAUD;
  localparam int HALF   = CPB / 2;
  localparam int T      = IDLE_BITS * CPB;
  localparam int CNT_W  = $clog2(CPB + 1);
  localparam int BIT_W  = $clog2(WIDTH + 1);
  localparam int IDLE_W = $clog2(T + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t             state_q, state_d;
  logic               rx_meta_q, rxs_q, rxs_prev_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic               pend_valid_q, pend_valid_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               last_due_q, last_due_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               fe_q, fe_d;
  logic               ov_q, ov_d;
  logic               char_good, push, push_last, slot_free;
`ifdef AXIS_UART_RX_PARITY_EN
  logic               par_err_q, par_err_d;
`endif

  // Character FSM: bit timing and sampling.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    char_good = 1'b0;
    fe_d      = 1'b0;
`ifdef AXIS_UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rxs_prev_q && !rxs_q) state_d = S_START;
      end
      S_START: begin
        // Mid-start sample: a high line here was only a glitch.
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d   = '0;
          shift_d = WIDTH'({rxs_q, shift_q} >> 1);
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_W'(WIDTH - 1)) begin
`ifdef AXIS_UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
`ifdef AXIS_UART_RX_PARITY_EN
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d     = '0;
          par_err_d = rxs_q ^ (^shift_q);
          state_d   = S_STOP;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_STOP: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
`ifdef AXIS_UART_RX_PARITY_EN
          if (rxs_q && !par_err_q) char_good = 1'b1;
`else
          if (rxs_q) char_good = 1'b1;
`endif
          else fe_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending byte, idle timeout and output slot.
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    idle_d       = idle_q;
    last_due_d   = last_due_q;
    ov_d         = 1'b0;
    push         = 1'b0;
    push_last    = 1'b0;
    slot_free    = !valid_q || m_axis_ready;

    if (state_q != S_IDLE) begin
      idle_d = '0;
    end else if (pend_valid_q && !last_due_q) begin
      idle_d = idle_q + 1'b1;
      if (idle_q == IDLE_W'(T - 1)) last_due_d = 1'b1;
    end

    if (char_good) begin
      if (pend_valid_q) begin
        // A timeout that already fired still marks the held byte as last.
        if (slot_free) begin
          push      = 1'b1;
          push_last = last_due_q;
        end else begin
          ov_d = 1'b1;
        end
      end
      pend_d       = shift_q;
      pend_valid_d = 1'b1;
      last_due_d   = 1'b0;
      idle_d       = '0;
    end else if (last_due_q && slot_free) begin
      push         = 1'b1;
      push_last    = 1'b1;
      pend_valid_d = 1'b0;
      last_due_d   = 1'b0;
      idle_d       = '0;
    end

    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q && !m_axis_ready;
    if (push) begin
      data_d  = pend_q;
      last_d  = push_last;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      pend_valid_q <= 1'b0;
      idle_q       <= '0;
      last_due_q   <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      fe_q         <= 1'b0;
      ov_q         <= 1'b0;
`ifdef AXIS_UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= uart_rx;
      rxs_q        <= rx_meta_q;
      rxs_prev_q   <= rxs_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      pend_valid_q <= pend_valid_d;
      idle_q       <= idle_d;
      last_due_q   <= last_due_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      fe_q         <= fe_d;
      ov_q         <= ov_d;
`ifdef AXIS_UART_RX_PARITY_EN
      par_err_q    <= par_err_d;
`endif
    end
  end

  // Pure data registers; their contents only matter once qualified.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    pend_q  <= pend_d;
  end

  assign m_axis_data  = data_q;
  assign m_axis_valid = valid_q;
  assign m_axis_last  = last_q;
  assign frame_err    = fe_q;
  assign overrun      = ov_q;

endmodule

// File: tb/tb_axis_uart_rx.sv
// Directed testbench for axis_uart_rx (CPB=10, T=40).
module tb_axis_uart_rx;

  localparam int CPB = 10;
  localparam int T   = 40;
`ifdef AXIS_UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Drive edge -> first flop (1), sync (2), half bit, data+parity+stop, timeout+1.
  localparam int LAT_LAST = 1 + 2 + CPB/2 + (8 + PBITS + 1)*CPB + T + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] m_axis_data;
  logic       m_axis_valid;
  logic       m_axis_last;
  logic       m_axis_ready;
  logic       frame_err;
  logic       overrun;

  axis_uart_rx #(.WIDTH(8), .CLK_RATE(1000000), .BAUD(100000), .IDLE_BITS(4)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_last(m_axis_last),
    .m_axis_ready(m_axis_ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records accepted beats and pulse cycles.
  logic [7:0] beat_data [0:63];
  logic       beat_last [0:63];
  int nbeats = 0, fe_cnt = 0, ov_cnt = 0, rise_cyc = 0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_valid && m_axis_ready && nbeats < 64) begin
        beat_data[nbeats] <= m_axis_data;
        beat_last[nbeats] <= m_axis_last;
        nbeats <= nbeats + 1;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun)   ov_cnt <= ov_cnt + 1;
      if (m_axis_valid && !prev_valid) rise_cyc <= cyc;
    end
    prev_valid <= m_axis_valid;
  end

  int n_tests = 0, n_fail = 0;
  int last_c0 = 0;
  int base, fe0, ov0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    last_c0 = cyc;
    uart_rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk); #1;
      uart_rx = b[i];
    end
`ifdef AXIS_UART_RX_PARITY_EN
    repeat (CPB) @(posedge clk); #1;
    uart_rx = ^b;
`endif
    repeat (CPB) @(posedge clk); #1;
    uart_rx = stop_bit;
    repeat (CPB) @(posedge clk); #1;
    uart_rx = 1'b1;
  endtask

  task automatic wait_beats(input int want, input int budget);
    int k = 0;
    while ((nbeats - base) < want && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic mark;
    base = nbeats; fe0 = fe_cnt; ov0 = ov_cnt;
  endtask

  initial begin
    rst = 1'b1; uart_rx = 1'b1; m_axis_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_valid", m_axis_valid, 0);
    check("rst_data",  m_axis_data, 0);
    check("rst_last",  m_axis_last, 0);
    check("rst_fe",    frame_err, 0);
    check("rst_ov",    overrun, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Single byte closes its own packet after the idle timeout.
    mark();
    send_byte(8'hA5, 1'b1);
    wait_beats(1, 300);
    check("t1_lat",  rise_cyc - last_c0, LAT_LAST);
    repeat (60) @(posedge clk); #1;
    check("t1_cnt",  nbeats - base, 1);
    check("t1_data", beat_data[base], 8'hA5);
    check("t1_last", beat_last[base], 1);
    check("t1_fe",   fe_cnt - fe0, 0);
    check("t1_ov",   ov_cnt - ov0, 0);

    // Back-to-back packet of three.
    mark();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    wait_beats(3, 300);
    repeat (60) @(posedge clk); #1;
    check("t2_cnt",   nbeats - base, 3);
    check("t2_d0",    beat_data[base],   8'h11);
    check("t2_l0",    beat_last[base],   0);
    check("t2_d1",    beat_data[base+1], 8'h22);
    check("t2_l1",    beat_last[base+1], 0);
    check("t2_d2",    beat_data[base+2], 8'h33);
    check("t2_l2",    beat_last[base+2], 1);

    // Bad stop bit after a good byte.
    mark();
    send_byte(8'h77, 1'b1);
    send_byte(8'h5A, 1'b0);
    wait_beats(1, 300);
    repeat (60) @(posedge clk); #1;
    check("t3_fe",   fe_cnt - fe0, 1);
    check("t3_cnt",  nbeats - base, 1);
    check("t3_data", beat_data[base], 8'h77);
    check("t3_last", beat_last[base], 1);

    // Short low glitch on an idle line.
    mark();
    @(posedge clk); #1; uart_rx = 1'b0;
    repeat (3) @(posedge clk); #1; uart_rx = 1'b1;
    repeat (100) @(posedge clk); #1;
    check("t4_cnt", nbeats - base, 0);
    check("t4_fe",  fe_cnt - fe0, 0);

    // Stalled output: third byte overruns the second.
    mark();
    m_axis_ready = 1'b0;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    check("t5_ov_a",   ov_cnt - ov0, 0);
    send_byte(8'h03, 1'b1);
    check("t5_ov_b",   ov_cnt - ov0, 1);
    repeat (T + 20) @(posedge clk); #1;
    check("t5_hold_v", m_axis_valid, 1);
    check("t5_hold_d", m_axis_data, 8'h01);
    check("t5_hold_l", m_axis_last, 0);
    check("t5_none",   nbeats - base, 0);
    m_axis_ready = 1'b1;
    wait_beats(2, 20);
    repeat (60) @(posedge clk); #1;
    check("t5_cnt", nbeats - base, 2);
    check("t5_d0",  beat_data[base],   8'h01);
    check("t5_l0",  beat_last[base],   0);
    check("t5_d1",  beat_data[base+1], 8'h03);
    check("t5_l1",  beat_last[base+1], 1);
    check("t5_ov",  ov_cnt - ov0, 1);

    // Reset in the middle of 0x3C, then a clean 0xC3.
    @(posedge clk); #1; uart_rx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (CPB) @(posedge clk); #1;
      uart_rx = (i == 2);
    end
    repeat (4) @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_rst_v", m_axis_valid, 0);
    check("t6_rst_d", m_axis_data, 0);
    check("t6_rst_l", m_axis_last, 0);
    repeat (5) @(posedge clk); #1; uart_rx = 1'b1;
    repeat (2) @(posedge clk); #1; rst = 1'b0;
    repeat (20) @(posedge clk); #1;
    mark();
    send_byte(8'hC3, 1'b1);
    wait_beats(1, 300);
    repeat (80) @(posedge clk); #1;
    check("t6_cnt",  nbeats - base, 1);
    check("t6_data", beat_data[base], 8'hC3);
    check("t6_last", beat_last[base], 1);
    check("t6_fe",   fe_cnt - fe0, 0);
    check("t6_ov",   ov_cnt - ov0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
